// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT BRAM load controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package gat_pkg;

  // Run sequencer states. The numeric encoding is visible in gat_debug_1.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } gat_state_e;

  // Host addresses are byte addresses; BRAM addresses are 32-bit word addresses.
  localparam int BYTE2WORD_SHIFT = 2;

  // Field offsets inside gat_debug_1.
  localparam int DBG_LAYER_BIT = 0;
  localparam int DBG_ERR_BIT   = 1;
  localparam int DBG_STATE_LSB = 2;
  localparam int DBG_SEEN_LSB  = 5;

  // Optional load counters: per-channel accepted-write count and rejected-write count.
  localparam int CNT_W = 10;
  localparam int REJ_W = 2;

  // Host writes (and load_done tracking) are only honoured while the core is not running.
  function automatic logic host_window_open(input gat_state_e s);
    return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/gat_wr_decode.sv
// Host write decode: accept check, byte->word address slicing, one-hot BRAM strobe.
// Latency: accept/reject combinational; BRAM strobe/address/data registered, 1 cycle.
// Backpressure: none; a write that cannot be accepted is flagged as rejected and dropped.
module gat_wr_decode
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH = 32,
  parameter int NUM_CH    = 3,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 24,
  parameter int CH_DEPTH  = 242101
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_open,
  input  logic                                i_wr_en,
  input  logic [CH_W-1:0]                     i_wr_ch,
  input  logic [ADDR_W+BYTE2WORD_SHIFT-1:0]   i_wr_addr,
  input  logic [TOP_WIDTH-1:0]                i_wr_data,
  output logic                                o_accept,
  output logic                                o_reject,
  output logic [NUM_CH-1:0]                   o_bram_ena,
  output logic [NUM_CH-1:0]                   o_bram_wea,
  output logic [ADDR_W-1:0]                   o_bram_addr,
  output logic [DATA_W-1:0]                   o_bram_din
);

  localparam int                HOST_AW = ADDR_W + BYTE2WORD_SHIFT;
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(CH_DEPTH);
  localparam logic [CH_W:0]     NCH_V   = (CH_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] w_word;
  logic              w_aligned;
  logic              w_ch_ok;
  logic              w_addr_ok;
  logic              w_accept;
  logic [NUM_CH-1:0] w_onehot;
  logic              w_unused_data;

  logic [NUM_CH-1:0] r_stb;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;

  assign w_word    = i_wr_addr[HOST_AW-1:BYTE2WORD_SHIFT];
  assign w_aligned = (i_wr_addr[BYTE2WORD_SHIFT-1:0] == '0);
  assign w_ch_ok   = ({1'b0, i_wr_ch} < NCH_V);
  assign w_addr_ok = ({1'b0, w_word} < DEPTH_V);
  assign w_accept  = i_wr_en & i_open & w_aligned & w_ch_ok & w_addr_ok;

  // Host data above DATA_W is intentionally discarded.
  assign w_unused_data = ^i_wr_data[TOP_WIDTH-1:DATA_W];

  // Decode the target channel into a one-hot strobe vector.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_onehot[i] = (i_wr_ch == CH_W'(i));
    end
  end

  // Register the strobe; address/data only move on an accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb  <= '0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_stb <= w_accept ? w_onehot : '0;
      if (w_accept) begin
        r_addr <= w_word;
        r_din  <= i_wr_data[DATA_W-1:0];
      end
    end
  end

  assign o_accept    = w_accept;
  assign o_reject    = i_wr_en & ~w_accept;
  assign o_bram_ena  = r_stb;
  assign o_bram_wea  = r_stb;
  assign o_bram_addr = r_addr;
  assign o_bram_din  = r_din;

endmodule

// File: rtl/gat_bram_load_ctrl.sv
// Multi-channel host->BRAM load controller and per-layer core run sequencer.
// Latency: host write to BRAM strobe 1 cycle; core_start one cycle after required loads complete.
// Backpressure: none; writes outside the load window are dropped and raise sticky gat_error.
// Optional: define GAT_LOAD_CNT_EN to add per-channel/rejected write counters on gat_debug_2.
module gat_bram_load_ctrl
  import gat_pkg::*;
#(
  parameter int                TOP_WIDTH = 32,
  parameter int                NUM_CH    = 3,
  parameter int                CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int                ADDR_W    = 18,
  parameter int                DATA_W    = 24,
  parameter int                CH_DEPTH  = 242101,
  parameter logic [NUM_CH-1:0] L0_MASK   = 3'b111,
  parameter logic [NUM_CH-1:0] L1_MASK   = 3'b100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      gat_layer,
  input  logic                      host_wr_en,
  input  logic [CH_W-1:0]           host_wr_ch,
  input  logic [ADDR_W+1:0]         host_wr_addr,
  input  logic [TOP_WIDTH-1:0]      host_wr_data,
  input  logic [NUM_CH-1:0]         load_done,
  input  logic                      core_done,
  output logic [NUM_CH-1:0]         bram_ena,
  output logic [NUM_CH-1:0]         bram_wea,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic [DATA_W-1:0]         bram_din,
  output logic                      core_start,
  output logic                      core_layer,
  output logic                      gat_ready,
  output logic                      gat_error,
  output logic [TOP_WIDTH-1:0]      gat_debug_1,
  output logic [TOP_WIDTH-1:0]      gat_debug_2
);

  gat_state_e        r_state;
  gat_state_e        w_next;
  logic [NUM_CH-1:0] r_seen;
  logic              r_err;
  logic              r_layer;

  logic              w_open;
  logic              w_accept;
  logic              w_reject;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_seen_now;
  logic              w_start;
  logic              w_ready;
  logic [TOP_WIDTH-1:0] w_dbg1;

  assign w_open     = host_window_open(r_state);
  assign w_req      = gat_layer ? L1_MASK : L0_MASK;
  // A load_done arriving in the same cycle as the check counts toward completion.
  assign w_seen_now = r_seen | load_done;

  gat_wr_decode #(
    .TOP_WIDTH (TOP_WIDTH),
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CH_DEPTH  (CH_DEPTH)
  ) u_wr_decode (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_open      (w_open),
    .i_wr_en     (host_wr_en),
    .i_wr_ch     (host_wr_ch),
    .i_wr_addr   (host_wr_addr),
    .i_wr_data   (host_wr_data),
    .o_accept    (w_accept),
    .o_reject    (w_reject),
    .o_bram_ena  (bram_ena),
    .o_bram_wea  (bram_wea),
    .o_bram_addr (bram_addr),
    .o_bram_din  (bram_din)
  );

  // Run sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs of the run sequencer.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (w_accept || (|load_done)) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        if ((w_seen_now & w_req) == w_req) w_next = ST_START;
      end
      ST_START: begin
        w_start = 1'b1;
        w_next  = ST_BUSY;
      end
      ST_BUSY: begin
        if (core_done) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_ready = 1'b1;
        if (w_accept || (|load_done)) w_next = ST_LOAD;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Load-completion tracking, sticky error and per-run layer latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen  <= '0;
      r_err   <= 1'b0;
      r_layer <= 1'b0;
    end else begin
      if ((r_state == ST_BUSY) && core_done) begin
        r_seen <= '0;
      end else if (w_open) begin
        r_seen <= w_seen_now;
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end
      // Latch on entry to START so core_layer is valid alongside core_start.
      if ((r_state == ST_LOAD) && (w_next == ST_START)) begin
        r_layer <= gat_layer;
      end
    end
  end

  // Status word: {pad, done_seen, state, error, layer}.
  always_comb begin
    w_dbg1 = '0;
    w_dbg1[DBG_LAYER_BIT]           = r_layer;
    w_dbg1[DBG_ERR_BIT]             = r_err;
    w_dbg1[DBG_STATE_LSB +: 3]      = r_state;
    w_dbg1[DBG_SEEN_LSB +: NUM_CH]  = r_seen;
  end

  assign core_start  = w_start;
  assign core_layer  = r_layer;
  assign gat_ready   = w_ready;
  assign gat_error   = r_err;
  assign gat_debug_1 = w_dbg1;

`ifdef GAT_LOAD_CNT_EN
  localparam int FLAT_W = REJ_W + NUM_CH * CNT_W;

  logic [CNT_W-1:0]     r_cnt [NUM_CH];
  logic [REJ_W-1:0]     r_rej;
  logic                 w_cnt_clr;
  logic [FLAT_W-1:0]    w_flat;
  logic [TOP_WIDTH-1:0] w_dbg2;

  // Counters restart with each new load phase after a completed run.
  assign w_cnt_clr = (r_state == ST_DONE) && (w_next == ST_LOAD);

  // Saturating accepted-write counters per channel and a rejected-write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
      r_rej <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cnt_clr) begin
          r_cnt[i] <= (w_accept && (host_wr_ch == CH_W'(i))) ? CNT_W'(1) : '0;
        end else if (w_accept && (host_wr_ch == CH_W'(i)) && (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      if (w_cnt_clr) begin
        r_rej <= w_reject ? REJ_W'(1) : '0;
      end else if (w_reject && (r_rej != '1)) begin
        r_rej <= r_rej + REJ_W'(1);
      end
    end
  end

  // Pack {rej, cnt[NUM_CH-1..0]} and fit it to the host bus width.
  always_comb begin
    w_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_flat[i*CNT_W +: CNT_W] = r_cnt[i];
    end
    w_flat[NUM_CH*CNT_W +: REJ_W] = r_rej;
    w_dbg2 = '0;
    for (int b = 0; b < TOP_WIDTH; b++) begin
      if (b < FLAT_W) w_dbg2[b] = w_flat[b];
    end
  end

  assign gat_debug_2 = w_dbg2;
`else
  assign gat_debug_2 = '0;
`endif

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Self-checking bench for gat_bram_load_ctrl: directed steps plus randomized traffic
// checked every cycle against a behavioural model of the load/run rules.
module tb_gat_bram_load_ctrl;

  logic        clk;
  logic        rst_n;
  logic        gat_layer;
  logic        host_wr_en;
  logic [1:0]  host_wr_ch;
  logic [19:0] host_wr_addr;
  logic [31:0] host_wr_data;
  logic [2:0]  load_done;
  logic        core_done;
  logic [2:0]  bram_ena;
  logic [2:0]  bram_wea;
  logic [17:0] bram_addr;
  logic [23:0] bram_din;
  logic        core_start;
  logic        core_layer;
  logic        gat_ready;
  logic        gat_error;
  logic [31:0] gat_debug_1;
  logic [31:0] gat_debug_2;

  gat_bram_load_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gat_layer    (gat_layer),
    .host_wr_en   (host_wr_en),
    .host_wr_ch   (host_wr_ch),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .load_done    (load_done),
    .core_done    (core_done),
    .bram_ena     (bram_ena),
    .bram_wea     (bram_wea),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .core_start   (core_start),
    .core_layer   (core_layer),
    .gat_ready    (gat_ready),
    .gat_error    (gat_error),
    .gat_debug_1  (gat_debug_1),
    .gat_debug_2  (gat_debug_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phases of a run, numbered in the order the status word reports them.
  localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_BUSY = 3, P_DONE = 4;

  int          n_tests = 0;
  int          n_fail  = 0;

  int          m_phase;
  logic [2:0]  m_seen;
  logic        m_err;
  logic        m_layer;
  logic [2:0]  m_stb;
  logic [31:0] m_addr;
  logic [31:0] m_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_seen  = 3'b000;
    m_err   = 1'b0;
    m_layer = 1'b0;
    m_stb   = 3'b000;
    m_addr  = 32'd0;
    m_din   = 32'd0;
  endtask

  // Apply one clock edge's worth of the load/run rules to the model.
  task automatic model_step();
    logic       open, ok, bad;
    logic [2:0] req, both;
    int         nxt;
    open = (m_phase == P_IDLE) || (m_phase == P_LOAD) || (m_phase == P_DONE);
    ok   = host_wr_en && open && (int'(host_wr_ch) < 3) && (host_wr_addr[1:0] == 2'b00)
           && (int'(host_wr_addr >> 2) < 242101);
    bad  = host_wr_en && !ok;
    m_stb = ok ? (3'b001 << host_wr_ch) : 3'b000;
    if (ok) begin
      m_addr = 32'(host_wr_addr >> 2);
      m_din  = host_wr_data & 32'h00FF_FFFF;
    end
    if (bad) m_err = 1'b1;
    req  = gat_layer ? 3'b100 : 3'b111;
    both = m_seen | load_done;
    nxt  = m_phase;
    case (m_phase)
      P_IDLE:  if (ok || load_done != 3'b000) nxt = P_LOAD;
      P_LOAD:  if ((both & req) == req) nxt = P_START;
      P_START: nxt = P_BUSY;
      P_BUSY:  if (core_done) nxt = P_DONE;
      default: if (ok || load_done != 3'b000) nxt = P_LOAD;
    endcase
    if (m_phase == P_BUSY && core_done) m_seen = 3'b000;
    else if (open) m_seen = both;
    if (m_phase == P_LOAD && nxt == P_START) m_layer = gat_layer;
    m_phase = nxt;
  endtask

  task automatic check_all();
    chk("bram_ena", 32'(bram_ena), 32'(m_stb));
    chk("bram_wea", 32'(bram_wea), 32'(m_stb));
    if (m_stb != 3'b000) begin
      chk("bram_addr", 32'(bram_addr), m_addr);
      chk("bram_din", 32'(bram_din), m_din);
    end
    chk("gat_error", 32'(gat_error), 32'(m_err));
    chk("gat_ready", 32'(gat_ready), 32'((m_phase == P_IDLE) || (m_phase == P_DONE)));
    chk("core_start", 32'(core_start), 32'(m_phase == P_START));
    if (m_phase != P_START) chk("core_layer", 32'(core_layer), 32'(m_layer));
    chk("dbg1_state", 32'(gat_debug_1[4:2]), 32'(m_phase));
    chk("dbg1_seen", 32'(gat_debug_1[7:5]), 32'(m_seen));
    chk("dbg1_err", 32'(gat_debug_1[1]), 32'(m_err));
    chk("dbg1_pad", 32'(gat_debug_1[31:8]), 32'd0);
    chk("dbg2", gat_debug_2, 32'd0);
  endtask

  // Drive one cycle of inputs, then check the post-edge outputs against the model.
  task automatic cyc(input logic we, input logic [1:0] ch, input logic [19:0] addr,
                     input logic [31:0] data, input logic [2:0] ld, input logic cd,
                     input logic lay);
    host_wr_en   = we;
    host_wr_ch   = ch;
    host_wr_addr = addr;
    host_wr_data = data;
    load_done    = ld;
    core_done    = cd;
    gat_layer    = lay;
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic idle(input logic lay);
    cyc(1'b0, 2'd0, 20'd0, 32'd0, 3'b000, 1'b0, lay);
  endtask

  initial begin
    logic [19:0] a;
    logic        we, cd, lay;
    logic [1:0]  ch;
    logic [2:0]  ld;
    int          sel;

    rst_n = 1'b0;
    gat_layer = 1'b0; host_wr_en = 1'b0; host_wr_ch = 2'd0; host_wr_addr = 20'd0;
    host_wr_data = 32'd0; load_done = 3'b000; core_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    check_all();
    chk("rst_ready", 32'(gat_ready), 32'd1);
    rst_n = 1'b1;

    // Basic write: byte address 0x10 -> word 4, data truncated to 24 bits.
    cyc(1'b1, 2'd0, 20'h00010, 32'hDEAD_BEEF, 3'b000, 1'b0, 1'b0);
    chk("w1_ena", 32'(bram_ena), 32'h1);
    chk("w1_addr", 32'(bram_addr), 32'd4);
    chk("w1_din", 32'(bram_din), 32'h00AD_BEEF);
    chk("w1_err", 32'(gat_error), 32'd0);

    // Rejected writes: misaligned, bad channel, word address at depth.
    cyc(1'b1, 2'd0, 20'h00006, 32'h1111_1111, 3'b000, 1'b0, 1'b0);
    chk("mis_ena", 32'(bram_ena), 32'd0);
    chk("mis_err", 32'(gat_error), 32'd1);
    cyc(1'b1, 2'd3, 20'h00020, 32'h2222_2222, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 20'(242101 * 4), 32'h3333_3333, 3'b000, 1'b0, 1'b0);
    chk("depth_ena", 32'(bram_ena), 32'd0);
    chk("depth_err", 32'(gat_error), 32'd1);
    // Last legal word is still accepted.
    cyc(1'b1, 2'd1, 20'(242100 * 4), 32'h0012_3456, 3'b000, 1'b0, 1'b0);
    chk("last_ena", 32'(bram_ena), 32'h2);

    // Layer 0 run: loads arrive in two parts.
    cyc(1'b0, 2'd0, 20'd0, 32'd0, 3'b001, 1'b0, 1'b0);
    chk("l0_nostart", 32'(core_start), 32'd0);
    cyc(1'b0, 2'd0, 20'd0, 32'd0, 3'b110, 1'b0, 1'b0);
    chk("l0_start", 32'(core_start), 32'd1);
    chk("l0_ready", 32'(gat_ready), 32'd0);
    idle(1'b0);
    chk("l0_pulse1", 32'(core_start), 32'd0);
    chk("l0_layer", 32'(core_layer), 32'd0);

    // BUSY: writes rejected; core_done with a simultaneous write ends the run.
    cyc(1'b1, 2'd1, 20'h00040, 32'hABCD_0001, 3'b000, 1'b0, 1'b0);
    chk("busy_ena", 32'(bram_ena), 32'd0);
    chk("busy_ready", 32'(gat_ready), 32'd0);
    cyc(1'b1, 2'd1, 20'h00044, 32'hABCD_0002, 3'b000, 1'b1, 1'b0);
    chk("done_ena", 32'(bram_ena), 32'd0);
    chk("done_ready", 32'(gat_ready), 32'd1);

    // Layer 1: only the weight channel is required; channels 0/1 alone must not start.
    cyc(1'b0, 2'd0, 20'd0, 32'd0, 3'b011, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("l1_nostart", 32'(core_start), 32'd0);
    cyc(1'b0, 2'd0, 20'd0, 32'd0, 3'b100, 1'b0, 1'b1);
    chk("l1_start", 32'(core_start), 32'd1);
    idle(1'b1);
    chk("l1_layer", 32'(core_layer), 32'd1);
    cyc(1'b0, 2'd0, 20'd0, 32'd0, 3'b000, 1'b1, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      we  = ($urandom_range(0, 9) < 5);
      ch  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = 20'($urandom_range(0, 242100) * 4);
        1:       a = 20'((242100 + $urandom_range(0, 1)) * 4);
        2:       a = 20'($urandom);
        default: a = 20'($urandom_range(0, 242100) * 4 + $urandom_range(1, 3));
      endcase
      ld  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      cd  = ($urandom_range(0, 5) == 0);
      lay = 1'($urandom_range(0, 1));
      cyc(we, ch, a, $urandom, ld, cd, lay);
    end

    // Drive into BUSY (bounded), then reset asynchronously mid-run.
    for (int k = 0; k < 20; k++) begin
      if (m_phase != P_BUSY) cyc(1'b0, 2'd0, 20'd0, 32'd0, 3'b111, 1'b0, 1'b0);
    end
    chk("pre_rst_busy", 32'(gat_debug_1[4:2]), 32'(P_BUSY));
    cyc(1'b1, 2'd2, 20'h00100, 32'h5555_5555, 3'b000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ready", 32'(gat_ready), 32'd1);
    chk("arst_start", 32'(core_start), 32'd0);
    chk("arst_err", 32'(gat_error), 32'd0);
    chk("arst_ena", 32'(bram_ena), 32'd0);
    chk("arst_state", 32'(gat_debug_1[4:2]), 32'(P_IDLE));
    #1;
    rst_n = 1'b1;

    // Post-reset: five writes to channel 2.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 2'd2, 20'(k * 4), 32'hC0DE_0000 + 32'(k), 3'b000, 1'b0, 1'b0);
      chk("ch2_ena", 32'(bram_ena), 32'h4);
    end
    idle(1'b0);
    chk("tail_ena", 32'(bram_ena), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gat_bram_load_ctrl.md
Name: gat_bram_load_ctrl

Overview:
- Multi-channel host-to-core BRAM load controller and run sequencer for the GAT accelerator, placed between the register-bank/AXI-BRAM side and gat_top.
- Converts 32-bit byte-addressed host writes into word-addressed writes for NUM_CH internal BRAMs, tracks per-channel load completion, and issues one core start per layer.
- Generalises the fixed three-channel pass-through wrapper: parametrised channel count, per-layer required-channel mask, sticky error reporting, registered write path and a run FSM.

Parameters:
- TOP_WIDTH, 32, host data bus width
- NUM_CH, 3, number of loadable BRAM channels
- CH_W, $clog2(NUM_CH) (min 1), channel-select width
- ADDR_W, 18, internal word-address width; host byte address is ADDR_W+2 bits
- DATA_W, 24, internal write data width (host data truncated to [DATA_W-1:0])
- CH_DEPTH, 242101, words per channel; word addresses >= CH_DEPTH are rejected
- L0_MASK, 3'b111, channels that must report load_done before a layer-0 run
- L1_MASK, 3'b100, channels that must report load_done before a layer-1 run (weights only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- gat_layer  in  1  layer select, sampled at start
- host_wr_en  in  1  host write strobe
- host_wr_ch  in  CH_W  target channel
- host_wr_addr  in  ADDR_W+2  byte address
- host_wr_data  in  TOP_WIDTH  write data
- load_done  in  NUM_CH  per-channel load-complete pulse/level
- core_done  in  1  core finished the current layer
- bram_ena  out  NUM_CH  per-channel enable
- bram_wea  out  NUM_CH  per-channel write enable
- bram_addr  out  ADDR_W  shared word address
- bram_din  out  DATA_W  shared write data
- core_start  out  1  one-cycle start pulse
- core_layer  out  1  latched layer for current run
- gat_ready  out  1  high in IDLE/DONE
- gat_error  out  1  sticky error
- gat_debug_1  out  TOP_WIDTH  status word
- gat_debug_2  out  TOP_WIDTH  counters (see optional feature)

Behaviour:
- Reset values: all outputs 0 except gat_ready=1; FSM=IDLE; done_seen=0; error=0.
- Write path, latency 1 cycle: an accepted write in cycle N drives bram_ena[ch]=bram_wea[ch]=1, bram_addr=host_wr_addr[ADDR_W+1:2] and bram_din=host_wr_data[DATA_W-1:0] in cycle N+1. Other channels' ena/wea stay 0.
- A write is accepted iff it arrives in state IDLE, LOAD or DONE, host_wr_ch<NUM_CH, host_wr_addr[1:0]==0 and word address<CH_DEPTH.
- A rejected write produces no BRAM strobe and sets sticky gat_error. gat_error clears only on reset.
- done_seen[NUM_CH] is sticky-ORed with load_done every cycle in IDLE, LOAD and DONE.
- req = gat_layer ? L1_MASK : L0_MASK.
- FSM states:
  - IDLE: any accepted write or load_done bit -> LOAD.
  - LOAD: when (done_seen & req)==req -> START. A load_done arriving in the same cycle counts.
  - START: core_start=1 for exactly 1 cycle; core_layer<=gat_layer; -> BUSY.
  - BUSY: all writes rejected with error; core_done -> DONE.
  - DONE: gat_ready=1; done_seen cleared on entry; -> LOAD on next accepted write or load_done.
- gat_ready is 0 in LOAD, START and BUSY.
- Simultaneous core_done and host write in BUSY: the write is rejected and the state moves to DONE.
- Asynchronous reset mid-run aborts to IDLE. A pending BRAM strobe is dropped.
- gat_debug_1 = {zero-pad, done_seen, state[2:0], gat_error, core_layer}.

Optional Feature:
- GAT_LOAD_CNT_EN defined: per-channel 10-bit saturating counters of accepted writes plus a 2-bit rejected-write counter; gat_debug_2 = {rej_cnt, cnt[NUM_CH-1..0]} zero-padded or truncated to TOP_WIDTH. Counters clear on reset and on DONE->LOAD.
- Not defined: counters absent; gat_debug_2 = 0.

Decomposition:
- gat_pkg holds the FSM state enum (IDLE, LOAD, START, BUSY, DONE; 3 bits), the debug field offsets and the byte-to-word shift constant (2).
- One sub-module, gat_wr_decode: combinational accept check and address/data slicing, followed by the registered one-hot strobe stage.

Test Plan:
- Reset, then write ch0 addr 0x0000_0010 data 0xDEADBEEF -> next cycle bram_ena=3'b001, wea=3'b001, bram_addr=4, bram_din=0xADBEEF (DATA_W=24); gat_error=0.
- Write with addr 0x6 (misaligned), then ch=3 (out of range), then word addr 242101 -> no strobes; gat_error=1 after the first and stays 1.
- gat_layer=0; pulse load_done 3'b001, then 3'b110 -> core_start high exactly one cycle after the 3'b110 cycle, core_layer=0, gat_ready=0 until core_done.
- In BUSY, host write ch1 -> no strobe, error set. core_done -> DONE, gat_ready=1.
- Layer 1: after DONE, set gat_layer=1 and pulse load_done 3'b100 only -> core_start with core_layer=1. load_done 3'b011 alone must not start.
- Assert rst_n low during BUSY -> immediately IDLE, gat_ready=1, core_start=0, error=0. With GAT_LOAD_CNT_EN, 5 writes to ch2 -> gat_debug_2 ch2 field=5.
